step_accum_counter: RTL and testbench
=====================================

# step_accum_counter

Parametrised, registered up/down step counter with selectable wrap or saturate arithmetic and overflow status. It generalises the team's fixed 2-bit add-one adder into a WIDTH-bit accumulator that holds state across cycles. It serves as the general counting and stepping primitive for address generators, loop counters and event tallies in the datapath.

## Interface
- `WIDTH`, default 8: bit width of `count`, `step` and `load_val`; legal range 2 to 32.
- `RESET_VAL`, default 0: value of `count` after reset or clear; must fit in WIDTH bits.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous clear to RESET_VAL; also clears `stat_sticky`.
- `load` in 1: synchronous load of `load_val` into `count`.
- `load_val` in WIDTH: value to load.
- `en` in 1: when high, apply one step this cycle.
- `up` in 1: 1 = add `step`; 0 = subtract `step`.
- `step` in WIDTH: unsigned step magnitude.
- `sat` in 1: 1 = saturate at bounds; 0 = wrap modulo 2^WIDTH.
- `count` out WIDTH: registered counter value.
- `stat` out 1: registered one-cycle pulse; high in the cycle after a step that crossed a bound.
- `stat_sticky` out 1: registered; set on any bound crossing, held until `clear` or `reset`.
- `at_max` out 1: combinational, `count` == 2^WIDTH-1.
- `at_min` out 1: combinational, `count` == 0.

## Operation
- Priority per edge: `reset` > `clear` > `load` > `en` > hold.
- Reset (asynchronous, immediate, independent of `clk`):
  - `count` = RESET_VAL, `stat` = 0, `stat_sticky` = 0.
- `clear`:
  - `count` = RESET_VAL, `stat` = 0, `stat_sticky` = 0.
- `load`:
  - `count` = `load_val`, `stat` = 0.
  - `stat_sticky` unchanged.
  - `en` ignored that cycle.
- `en` step arithmetic, computed in WIDTH+1 bits:
  - `up`=1: sum = {0,count} + {0,step}; crossing = sum[WIDTH].
  - `up`=0: diff = {0,count} - {0,step}; crossing = diff[WIDTH] (borrow).
  - No crossing: `count` = low WIDTH bits of the result.
  - Crossing with `sat`=0: `count` = low WIDTH bits (wrap).
  - Crossing with `sat`=1: `count` = 2^WIDTH-1 if `up`, else 0.
  - Crossing: `stat` = 1 next cycle, `stat_sticky` = 1.
  - No crossing: `stat` = 0.
- Reaching a bound exactly is not a crossing:
  - 254+1 in 8 bits gives 255 with `stat`=0.
  - 1-1 gives 0 with `stat`=0.
- `step` = 0 with `en`: `count` unchanged, `stat` = 0.
- Idle (no `en`/`load`/`clear`): `count` and `stat_sticky` hold, `stat` = 0.
- `up`, `sat` and `step` are sampled only in cycles where `en` is high; they may change freely between steps.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on `count` after edge N.
- `stat` is aligned with the updated `count`, both valid after the same edge, and lasts exactly one cycle unless the next step also crosses.
- Back-to-back steps are supported every cycle; there is no stall or handshake.
- `at_max` and `at_min` follow `count` combinationally with no added latency.
- Reset asserted mid-run forces outputs within the same cycle. Release is synchronised by the integrating block; the first step is taken at the first edge after deassertion.
- `clear` and `load` together: `clear` wins.

## Test plan
- Reset: WIDTH=8, RESET_VAL=5, assert `reset` mid-count at `count`=0x37 -> `count`=5 and `stat`/`stat_sticky`=0 immediately, without waiting for a clock edge.
- Wrap increment: WIDTH=2, `step`=1, `up`=1, `sat`=0, `en` held for 5 cycles from 0 -> `count` 1,2,3,0,1; `stat` high only in the cycle `count`=0; `stat_sticky` stays 1 afterwards.
- Saturate: WIDTH=8, load 250, then `step`=10, `up`=1, `sat`=1 -> `count`=255, `stat`=1. Next `step`=3, `up`=0 -> `count`=252, `stat`=0, `stat_sticky`=1.
- Down wrap and exact bound: WIDTH=8, load 3. `step`=3, `up`=0 -> `count`=0, `stat`=0, `at_min`=1. Then `step`=1, `sat`=0 -> `count`=255, `stat`=1, `at_max`=1.
- Priority: same cycle `clear`=1, `load`=1 (`load_val`=0x80), `en`=1 -> `count`=RESET_VAL, `stat_sticky`=0. Next cycle `load`=1 with `en`=1 -> `count`=0x80, no step applied.
- Zero step and idle: `en`=1, `step`=0 at `count`=255 with `up`=1 -> `count` stays 255 and `stat`=0. With `en`=0 for 3 cycles, `count` and `stat_sticky` hold.

Source files
------------

// File: rtl/step_accum_counter.sv
// Registered WIDTH-bit up/down step counter with wrap or saturate arithmetic.
// Flags bound crossings with a one-cycle pulse and a sticky status bit.
module step_accum_counter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             stat,
    output logic             stat_sticky,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] ResetVal = RESET_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] count_q, count_d;
    logic             stat_q, stat_d;
    logic             sticky_q, sticky_d;
    logic [WIDTH:0]   sum, diff, res;
    logic             crossing;

    // Extra top bit carries the overflow (up) or borrow (down).
    assign sum      = {1'b0, count_q} + {1'b0, step};
    assign diff     = {1'b0, count_q} - {1'b0, step};
    assign res      = up ? sum : diff;
    assign crossing = res[WIDTH];

    always_comb begin
        count_d  = count_q;
        stat_d   = 1'b0;
        sticky_d = sticky_q;
        if (clear) begin
            count_d  = ResetVal;
            sticky_d = 1'b0;
        end else if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (crossing && sat) begin
                count_d = up ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
            end else begin
                count_d = res[WIDTH-1:0];
            end
            if (crossing) begin
                stat_d   = 1'b1;
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= ResetVal;
            stat_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            stat_q   <= stat_d;
            sticky_q <= sticky_d;
        end
    end

    assign count       = count_q;
    assign stat        = stat_q;
    assign stat_sticky = sticky_q;
    assign at_max      = &count_q;
    assign at_min      = ~|count_q;

endmodule

// File: tb/tb_step_accum_counter.sv
// Directed-vector bench: an 8-bit counter (RESET_VAL=5) driven from a table,
// plus a 2-bit counter for the wrap sequence and a mid-cycle reset check.
module tb_step_accum_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-bit DUT
    logic       reset, clear, load, en, up, sat;
    logic [7:0] load_val, step, count;
    logic       stat, stat_sticky, at_max, at_min;

    step_accum_counter #(.WIDTH(8), .RESET_VAL(5)) dut (
        .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
        .en(en), .up(up), .step(step), .sat(sat), .count(count), .stat(stat),
        .stat_sticky(stat_sticky), .at_max(at_max), .at_min(at_min)
    );

    // 2-bit DUT
    logic       reset2, en2;
    logic [1:0] count2;
    logic       stat2, sticky2, max2, min2;

    step_accum_counter #(.WIDTH(2), .RESET_VAL(0)) dut2 (
        .clk(clk), .reset(reset2), .clear(1'b0), .load(1'b0), .load_val(2'd0),
        .en(en2), .up(1'b1), .step(2'd1), .sat(1'b0), .count(count2), .stat(stat2),
        .stat_sticky(sticky2), .at_max(max2), .at_min(min2)
    );

    typedef struct {
        logic       clr, ld;
        logic [7:0] lv;
        logic       en, up;
        logic [7:0] st;
        logic       sat;
        logic [7:0] e_count;
        logic       e_stat, e_sticky, e_max, e_min;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic clr, input logic ld, input logic [7:0] lv,
                       input logic e, input logic u, input logic [7:0] st, input logic s,
                       input logic [7:0] ec, input logic es, input logic ess,
                       input logic emax, input logic emin);
        vec_t v;
        v = '{clr, ld, lv, e, u, st, s, ec, es, ess, emax, emin};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // clr ld lv  en up st  sat | count stat sticky max min
        add(0, 1, 250, 0, 0, 0,  0,   250, 0, 0, 0, 0);  // load 250
        add(0, 0, 0,   1, 1, 10, 1,   255, 1, 1, 1, 0);  // saturate up
        add(0, 0, 0,   1, 0, 3,  1,   252, 0, 1, 0, 0);  // step down, sticky holds
        add(0, 1, 3,   0, 0, 0,  0,   3,   0, 1, 0, 0);  // load 3
        add(0, 0, 0,   1, 0, 3,  0,   0,   0, 1, 0, 1);  // exact lower bound
        add(0, 0, 0,   1, 0, 1,  0,   255, 1, 1, 1, 0);  // down wrap
        add(1, 1, 128, 1, 1, 1,  0,   5,   0, 0, 0, 0);  // clear beats load and en
        add(0, 1, 128, 1, 1, 1,  0,   128, 0, 0, 0, 0);  // load beats en
        add(0, 1, 254, 0, 0, 0,  0,   254, 0, 0, 0, 0);
        add(0, 0, 0,   1, 1, 1,  0,   255, 0, 0, 1, 0);  // exact upper bound
        add(0, 0, 0,   1, 1, 0,  0,   255, 0, 0, 1, 0);  // zero step
        add(0, 0, 0,   1, 1, 1,  0,   0,   1, 1, 0, 1);  // up wrap
        add(0, 0, 0,   0, 1, 7,  1,   0,   0, 1, 0, 1);  // idle x3
        add(0, 0, 0,   0, 0, 9,  0,   0,   0, 1, 0, 1);
        add(0, 0, 0,   0, 1, 1,  1,   0,   0, 1, 0, 1);
        add(0, 1, 1,   0, 0, 0,  0,   1,   0, 1, 0, 0);
        add(0, 0, 0,   1, 0, 1,  1,   0,   0, 1, 0, 1);  // 1-1 exact, no crossing
        add(0, 1, 55,  0, 0, 0,  0,   55,  0, 1, 0, 0);  // count = 0x37

        reset = 1'b1; clear = 0; load = 0; en = 0; up = 0; sat = 0;
        load_val = 0; step = 0;
        reset2 = 1'b1; en2 = 0;
        #1;
        check("reset_count", int'(count), 5);
        check("reset_sticky", int'(stat_sticky), 0);
        check("reset2_count", int'(count2), 0);
        @(negedge clk);
        reset = 1'b0;
        reset2 = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            clear = vecs[i].clr; load = vecs[i].ld; load_val = vecs[i].lv;
            en = vecs[i].en; up = vecs[i].up; step = vecs[i].st; sat = vecs[i].sat;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), int'(count), int'(vecs[i].e_count));
            check($sformatf("v%0d_stat", i), int'(stat), int'(vecs[i].e_stat));
            check($sformatf("v%0d_sticky", i), int'(stat_sticky), int'(vecs[i].e_sticky));
            check($sformatf("v%0d_at_max", i), int'(at_max), int'(vecs[i].e_max));
            check($sformatf("v%0d_at_min", i), int'(at_min), int'(vecs[i].e_min));
        end

        // Mid-cycle asynchronous reset at count 0x37 with sticky set
        @(negedge clk);
        load = 0; en = 0; clear = 0;
        #2 reset = 1'b1;
        #1;
        check("async_reset_count", int'(count), 5);
        check("async_reset_stat", int'(stat), 0);
        check("async_reset_sticky", int'(stat_sticky), 0);
        @(negedge clk);
        reset = 1'b0;

        // 2-bit wrap sequence
        begin
            logic [1:0] exp_c[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            logic       exp_s[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
            logic       exp_k[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            en2 = 1'b1;
            for (int i = 0; i < 5; i++) begin
                @(posedge clk);
                #1;
                check($sformatf("w2_%0d_count", i), int'(count2), int'(exp_c[i]));
                check($sformatf("w2_%0d_stat", i), int'(stat2), int'(exp_s[i]));
                check($sformatf("w2_%0d_sticky", i), int'(sticky2), int'(exp_k[i]));
            end
            en2 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
